// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Parametrised raster timing generator for the arcade board video path. A
// pixel-rate clock enable (ce_pix) advances a horizontal/vertical counter
// pair on the system clock. Blanking, sync, data-enable, line/frame start
// strobes and a blanked copy of the incoming pixel are all registered from
// the *next* counter values, so every output lines up with hcnt/vcnt.
//
// Ports:
//   clk_sys      in   sole clock
//   reset        in   synchronous, active-high; wins over ce_pix
//   ce_pix       in   pixel clock enable, one clk_sys cycle wide
//   mask_en      in   blank the first LEFT_MASK pixels of every line
//   rgb_in       in   pixel from the video board, valid at the ce edge that
//                     advances the counters onto that pixel
//   rgb_out      out  rgb_in, or zero while hb | vb
//   hcnt, vcnt   out  current pixel column / line
//   hb, vb       out  horizontal / vertical blank, active high
//   hs, vs       out  sync, active level HS_POL / VS_POL
//   de           out  ~hb & ~vb
//   line_start   out  one-cycle strobe after the ce that enters hcnt = 0
//   frame_start  out  one-cycle strobe after the ce that enters (0,0)
// -----------------------------------------------------------------------------
module video_timing_gen #(
  parameter int H_W          = 9,
  parameter int V_W          = 9,
  parameter int H_TOTAL      = 318,
  parameter int H_ACTIVE     = 256,
  parameter int H_SYNC_START = 283,
  parameter int H_SYNC_END   = 303,
  parameter int V_TOTAL      = 256,
  parameter int V_ACTIVE     = 240,
  parameter int V_SYNC_START = 251,
  parameter int V_SYNC_END   = 254,
  parameter int LEFT_MASK    = 5,
  parameter int RGB_W        = 24,
  parameter bit HS_POL       = 1'b0,
  parameter bit VS_POL       = 1'b0
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             ce_pix,
  input  logic             mask_en,
  input  logic [RGB_W-1:0] rgb_in,
  output logic [RGB_W-1:0] rgb_out,
  output logic [H_W-1:0]   hcnt,
  output logic [V_W-1:0]   vcnt,
  output logic             hb,
  output logic             vb,
  output logic             hs,
  output logic             vs,
  output logic             de,
  output logic             line_start,
  output logic             frame_start
);

  // ---------------------------------------------------------------------------
  // Parameter legality, checked at elaboration
  // ---------------------------------------------------------------------------
  if (!(H_ACTIVE < H_SYNC_START && H_SYNC_START < H_SYNC_END &&
        H_SYNC_END <= H_TOTAL && longint'(H_TOTAL) <= (longint'(1) << H_W)))
  begin : g_bad_h_timing
    $error("video_timing_gen: illegal horizontal timing parameters");
  end

  if (!(V_ACTIVE < V_SYNC_START && V_SYNC_START < V_SYNC_END &&
        V_SYNC_END <= V_TOTAL && longint'(V_TOTAL) <= (longint'(1) << V_W)))
  begin : g_bad_v_timing
    $error("video_timing_gen: illegal vertical timing parameters");
  end

  if (!(LEFT_MASK < H_ACTIVE)) begin : g_bad_left_mask
    $error("video_timing_gen: LEFT_MASK must be below H_ACTIVE");
  end

  // Full-width compare constants so every counter compare is unsigned at
  // H_W / V_W bits.
  localparam logic [H_W-1:0] H_LAST = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT  = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] H_SS   = H_W'(H_SYNC_START);
  localparam logic [H_W-1:0] H_SE   = H_W'(H_SYNC_END);
  localparam logic [H_W-1:0] H_MASK = H_W'(LEFT_MASK);
  localparam logic [V_W-1:0] V_LAST = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ACT  = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] V_SS   = V_W'(V_SYNC_START);
  localparam logic [V_W-1:0] V_SE   = V_W'(V_SYNC_END);

  // ---------------------------------------------------------------------------
  // Next-position decode
  // ---------------------------------------------------------------------------
  logic           h_wrap;
  logic [H_W-1:0] h_next;
  logic [V_W-1:0] v_next;
  logic           hb_next;
  logic           vb_next;
  logic           hs_next;
  logic           vs_next;

  // NOTE: every signal driven here gets a default before any conditional
  // assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    h_wrap = (hcnt == H_LAST);
    h_next = h_wrap ? '0 : hcnt + H_W'(1);
    v_next = vcnt;
    if (h_wrap) begin
      v_next = (vcnt == V_LAST) ? '0 : vcnt + V_W'(1);
    end

    hb_next = (h_next >= H_ACT) | (mask_en & (h_next < H_MASK));
    vb_next = (v_next >= V_ACT);
    hs_next = ((h_next >= H_SS) && (h_next < H_SE)) ? HS_POL : ~HS_POL;
    // v_next only moves on an h wrap, so vs can only change there too.
    vs_next = ((v_next >= V_SS) && (v_next < V_SE)) ? VS_POL : ~VS_POL;
  end

  // ---------------------------------------------------------------------------
  // Registered counters and outputs
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      // Park on the last pixel of the last line so the first ce enters (0,0).
      hcnt        <= H_LAST;
      vcnt        <= V_LAST;
      hb          <= 1'b1;
      vb          <= 1'b1;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      rgb_out     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      // Strobes last exactly one clk_sys cycle, even with ce held high only
      // once in a while.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (ce_pix) begin
        hcnt        <= h_next;
        vcnt        <= v_next;
        hb          <= hb_next;
        vb          <= vb_next;
        hs          <= hs_next;
        vs          <= vs_next;
        de          <= ~hb_next & ~vb_next;
        rgb_out     <= (hb_next | vb_next) ? '0 : rgb_in;
        line_start  <= (h_next == '0);
        frame_start <= (h_next == '0) && (v_next == '0);
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//
// Two instances share clk_sys, mask_en and rgb_in:
//   dut_a  default geometry (318 x 256)
//   dut_b  default line, short 16-line frame, for whole-frame behaviour
// Each step drives inputs, pushes the expected outputs of both instances
// onto per-instance scoreboard queues, clocks once, then pops and compares
// #1 after the edge. Directed counts and fixed expected values from the
// timing description are checked on top of the scoreboard.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

  typedef struct packed {
    logic [8:0]  hcnt;
    logic [8:0]  vcnt;
    logic        hb;
    logic        vb;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [23:0] rgb;
  } obs_t;

  localparam int HT  = 318;
  localparam int HA  = 256;
  localparam int HSS = 283;
  localparam int HSE = 303;
  localparam int LM  = 5;

  logic        clk_sys;
  logic        rst_a, ce_a, rst_b, ce_b;
  logic        mask_en;
  logic [23:0] rgb_in;

  logic [23:0] rgb_a, rgb_b;
  logic [8:0]  hcnt_a, hcnt_b, vcnt_a, vcnt_b;
  logic        hb_a, vb_a, hs_a, vs_a, de_a, ls_a, fs_a;
  logic        hb_b, vb_b, hs_b, vs_b, de_b, ls_b, fs_b;

  obs_t oa, ob;
  assign oa = {hcnt_a, vcnt_a, hb_a, vb_a, hs_a, vs_a, de_a, ls_a, fs_a, rgb_a};
  assign ob = {hcnt_b, vcnt_b, hb_b, vb_b, hs_b, vs_b, de_b, ls_b, fs_b, rgb_b};

  video_timing_gen dut_a (
    .clk_sys(clk_sys), .reset(rst_a), .ce_pix(ce_a), .mask_en(mask_en),
    .rgb_in(rgb_in), .rgb_out(rgb_a), .hcnt(hcnt_a), .vcnt(vcnt_a),
    .hb(hb_a), .vb(vb_a), .hs(hs_a), .vs(vs_a), .de(de_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  video_timing_gen #(
    .V_TOTAL(16), .V_ACTIVE(10), .V_SYNC_START(12), .V_SYNC_END(14)
  ) dut_b (
    .clk_sys(clk_sys), .reset(rst_b), .ce_pix(ce_b), .mask_en(mask_en),
    .rgb_in(rgb_in), .rgb_out(rgb_b), .hcnt(hcnt_b), .vcnt(vcnt_b),
    .hb(hb_b), .vb(vb_b), .hs(hs_b), .vs(vs_b), .de(de_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // ---------------------------------------------------------------------------
  // Scoreboard, reference model and checking
  // ---------------------------------------------------------------------------
  int   n_checks = 0;
  int   n_errors = 0;
  int   mh[2];
  int   mv[2];
  obs_t last[2];
  obs_t q_a[$];
  obs_t q_b[$];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Expected outputs after the coming edge, from the timing description.
  task automatic model_step(input int s, input bit rst, input bit ce);
    obs_t e;
    int   vt, va, vss, vse;
    vt  = (s == 0) ? 256 : 16;
    va  = (s == 0) ? 240 : 10;
    vss = (s == 0) ? 251 : 12;
    vse = (s == 0) ? 254 : 14;
    e   = '0;
    if (rst) begin
      mh[s]  = HT - 1;
      mv[s]  = vt - 1;
      e.hcnt = 9'(HT - 1);
      e.vcnt = 9'(vt - 1);
      e.hb   = 1'b1;
      e.vb   = 1'b1;
      e.hs   = 1'b1;
      e.vs   = 1'b1;
    end else if (ce) begin
      mh[s] = (mh[s] + 1) % HT;
      if (mh[s] == 0) mv[s] = (mv[s] + 1) % vt;
      e.hcnt = 9'(mh[s]);
      e.vcnt = 9'(mv[s]);
      e.hb   = (mh[s] >= HA) || (mask_en && (mh[s] < LM));
      e.vb   = (mv[s] >= va);
      e.hs   = !((mh[s] >= HSS) && (mh[s] < HSE));
      e.vs   = !((mv[s] >= vss) && (mv[s] < vse));
      e.de   = !e.hb && !e.vb;
      e.ls   = (mh[s] == 0);
      e.fs   = (mh[s] == 0) && (mv[s] == 0);
      e.rgb  = (e.hb || e.vb) ? 24'h0 : rgb_in;
    end else begin
      e    = last[s];
      e.ls = 1'b0;
      e.fs = 1'b0;
    end
    last[s] = e;
    if (s == 0) q_a.push_back(e);
    else        q_b.push_back(e);
  endtask

  task automatic step(input bit ca, input bit ra, input bit cb, input bit rb);
    ce_a  = ca;
    rst_a = ra;
    ce_b  = cb;
    rst_b = rb;
    model_step(0, ra, ca);
    model_step(1, rb, cb);
    @(posedge clk_sys);
    #1;
    check("sb_a", 64'(oa), 64'(q_a.pop_front()));
    check("sb_b", 64'(ob), 64'(q_b.pop_front()));
  endtask

  // One full line of continuous ce on dut_a, with random pixels.
  task automatic run_line(output int hs_low, output int de_n, output int hb_n,
                          output int ls_n, output int hb_rise_h);
    logic prev_hb;
    hs_low = 0; de_n = 0; hb_n = 0; ls_n = 0; hb_rise_h = -1;
    prev_hb = hb_a;
    for (int i = 0; i < HT; i++) begin
      rgb_in = 24'($urandom);
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (!hs_a) hs_low++;
      if (de_a)  de_n++;
      if (hb_a)  hb_n++;
      if (ls_a)  ls_n++;
      if (hb_a && !prev_hb && hb_rise_h < 0) hb_rise_h = int'(hcnt_a);
      prev_hb = hb_a;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    int hs_low, de_n, hb_n, ls_n, hb_rise_h;
    int bad_blank, bad_vis;
    int fs_n, fs_last, vs_low, vb_rise_h, vb_rise_v, vs_fall_h, vs_fall_v;
    logic prev_vb, prev_vs;

    mask_en = 1'b0;
    rgb_in  = 24'h0;
    rst_a   = 1'b1;
    rst_b   = 1'b1;
    ce_a    = 1'b0;
    ce_b    = 1'b0;

    // Reset state of both instances.
    step(1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    check("reset_state_a", 64'(oa),
          64'({9'd317, 9'd255, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0}));
    check("reset_state_b", 64'(ob),
          64'({9'd317, 9'd15, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0}));

    // Reset exit: first ce enters (0,0) with both strobes.
    rgb_in = 24'h123456;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("exit_pos_strobes", 64'({hcnt_a, vcnt_a, hb_a, vb_a, de_a, ls_a, fs_a, rgb_a}),
          64'({9'd0, 9'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 24'h123456}));
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("exit_strobes_clear", 64'({ls_a, fs_a, hcnt_a}), 64'({1'b0, 1'b0, 9'd0}));

    // Line 0, no mask: hb rise at 256, 20 hs pixels, line_start after 318 ce.
    run_line(hs_low, de_n, hb_n, ls_n, hb_rise_h);
    check("hb_rise_hcnt", 64'(hb_rise_h), 64'(256));
    check("hs_low_pixels", 64'(hs_low), 64'(20));
    check("de_pixels_nomask", 64'(de_n), 64'(256));
    check("ls_once_per_line", 64'(ls_n), 64'(1));
    check("ls_at_318", 64'({ls_a, hcnt_a, hb_a}), 64'({1'b1, 9'd0, 1'b0}));

    // Line 1, masked: hb over 0..4 and 256..317, de for 251 pixels.
    mask_en = 1'b1;
    run_line(hs_low, de_n, hb_n, ls_n, hb_rise_h);
    check("de_pixels_mask", 64'(de_n), 64'(251));
    check("hb_pixels_mask", 64'(hb_n), 64'(67));
    check("hb_mask_hcnt0", 64'({hcnt_a, hb_a, de_a}), 64'({9'd0, 1'b1, 1'b0}));

    // Mask toggled at hcnt=2 takes effect from hcnt=3.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("mask_hold_h2", 64'({hcnt_a, hb_a}), 64'({9'd2, 1'b1}));
    mask_en = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("mask_off_h3", 64'({hcnt_a, hb_a, de_a}), 64'({9'd3, 1'b0, 1'b1}));

    // Throttled ce (1 in 10) with white pixels; scoreboard covers holds.
    rgb_in    = 24'hFFFFFF;
    bad_blank = 0;
    bad_vis   = 0;
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 10; k++) begin
        step(k == 0, 1'b0, 1'b0, 1'b0);
        if ((hb_a || vb_a) && rgb_a != 24'h0) bad_blank++;
        if (de_a && rgb_a != 24'hFFFFFF)      bad_vis++;
      end
    end
    check("throttle_blank_rgb", 64'(bad_blank), 64'(0));
    check("throttle_visible_rgb", 64'(bad_vis), 64'(0));

    // Run on to (100,50); the model bounds the loop.
    while (!(mh[0] == 100 && mv[0] == 50)) begin
      rgb_in = 24'($urandom);
      step(1'b1, 1'b0, 1'b0, 1'b0);
    end
    check("mid_frame_pos", 64'({hcnt_a, vcnt_a}), 64'({9'd100, 9'd50}));

    // Reset mid-frame, with ce in the same cycle: reset wins.
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("mid_reset_state", 64'(oa),
          64'({9'd317, 9'd255, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h0}));
    rgb_in = 24'hA5A5A5;
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("mid_reset_exit", 64'({hcnt_a, vcnt_a, ls_a, fs_a, de_a, rgb_a}),
          64'({9'd0, 9'd0, 1'b1, 1'b1, 1'b1, 24'hA5A5A5}));

    // Whole frame on dut_b (318 x 16): vb/vs placement and frame period.
    fs_n      = 0;
    fs_last   = -1;
    vs_low    = 0;
    vb_rise_h = -1; vb_rise_v = -1;
    vs_fall_h = -1; vs_fall_v = -1;
    prev_vb   = vb_b;
    prev_vs   = vs_b;
    for (int i = 1; i <= HT * 16 + 1; i++) begin
      rgb_in = 24'($urandom);
      step(1'b0, 1'b0, 1'b1, 1'b0);
      if (fs_b) begin
        if (fs_n == 1) check("frame_period", 64'(i - fs_last), 64'(HT * 16));
        fs_n++;
        fs_last = i;
        check("fs_implies_ls", 64'(ls_b), 64'(1));
      end
      if (!vs_b) vs_low++;
      if (vb_b && !prev_vb && vb_rise_v < 0) begin
        vb_rise_h = int'(hcnt_b);
        vb_rise_v = int'(vcnt_b);
      end
      if (!vs_b && prev_vs && vs_fall_v < 0) begin
        vs_fall_h = int'(hcnt_b);
        vs_fall_v = int'(vcnt_b);
      end
      prev_vb = vb_b;
      prev_vs = vs_b;
    end
    check("frame_start_count", 64'(fs_n), 64'(2));
    check("vb_rise_pos", 64'({16'(vb_rise_h), 16'(vb_rise_v)}), 64'({16'd0, 16'd10}));
    check("vs_fall_pos", 64'({16'(vs_fall_h), 16'(vs_fall_v)}), 64'({16'd0, 16'd12}));
    check("vs_low_pixels", 64'(vs_low), 64'(2 * HT));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
